// File: rtl/cl_ocl_slice_pkg.sv
// Shared types for the CL OCL AXI-Lite register slice.
// Skid buffer state encoding and AXI-Lite response codes.
package cl_ocl_slice_pkg;

   typedef enum logic [1:0] {
      SKD_EMPTY,
      SKD_ONE,
      SKD_TWO
   } skd_state_e;

   localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXIL_RESP_DECERR = 2'b11;

endpackage

// File: rtl/cl_axil_skid_buf.sv
// Generic 2-entry skid buffer for one valid/ready channel.
// Fully registered: in_ready, out_valid and out_data come from flops.
module cl_axil_skid_buf
   import cl_ocl_slice_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk_main_a0,
   input  logic         rst_main_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   skd_state_e   state_q;
   skd_state_e   state_d;
   logic [W-1:0] skd_q;
   logic         in_fire;
   logic         load_out;
   logic         load_skd;
   logic         out_from_skd;

   assign in_fire   = in_valid & in_ready;
   assign out_valid = (state_q != SKD_EMPTY);

   always_comb begin
      state_d      = state_q;
      load_out     = 1'b0;
      load_skd     = 1'b0;
      out_from_skd = 1'b0;
      unique case (state_q)
         SKD_EMPTY: begin
            if (in_fire) begin
               state_d  = SKD_ONE;
               load_out = 1'b1;
            end
         end
         SKD_ONE: begin
            if (in_fire && out_ready) begin
               load_out = 1'b1;
            end else if (in_fire) begin
               state_d  = SKD_TWO;
               load_skd = 1'b1;
            end else if (out_ready) begin
               state_d  = SKD_EMPTY;
            end
         end
         SKD_TWO: begin
            if (out_ready) begin
               state_d      = SKD_ONE;
               load_out     = 1'b1;
               out_from_skd = 1'b1;
            end
         end
         default: state_d = SKD_EMPTY;
      endcase
   end

   // in_ready is registered from the next state so it never depends on out_ready.
   always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
      if (!rst_main_n) begin
         state_q  <= SKD_EMPTY;
         in_ready <= 1'b0;
         out_data <= '0;
         skd_q    <= '0;
      end else begin
         state_q  <= state_d;
         in_ready <= (state_d != SKD_TWO);
         if (load_out) out_data <= out_from_skd ? skd_q : in_data;
         if (load_skd) skd_q <= in_data;
      end
   end

endmodule

// File: rtl/cl_ocl_axil_skid_slice.sv
// AXI-Lite register slice between shell OCL port and CL decoder.
// Optional handshake counters: define CL_OCL_SLICE_STATS_EN.
module cl_ocl_axil_skid_slice
   import cl_ocl_slice_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic                clk_main_a0,
   input  logic                rst_main_n,
   input  logic                s_axi_awvalid,
   output logic                s_axi_awready,
   input  logic [ADDR_W-1:0]   s_axi_awaddr,
   input  logic                s_axi_wvalid,
   output logic                s_axi_wready,
   input  logic [DATA_W-1:0]   s_axi_wdata,
   input  logic [DATA_W/8-1:0] s_axi_wstrb,
   output logic                s_axi_bvalid,
   input  logic                s_axi_bready,
   output logic [1:0]          s_axi_bresp,
   input  logic                s_axi_arvalid,
   output logic                s_axi_arready,
   input  logic [ADDR_W-1:0]   s_axi_araddr,
   output logic                s_axi_rvalid,
   input  logic                s_axi_rready,
   output logic [DATA_W-1:0]   s_axi_rdata,
   output logic [1:0]          s_axi_rresp,
   output logic                m_axi_awvalid,
   input  logic                m_axi_awready,
   output logic [ADDR_W-1:0]   m_axi_awaddr,
   output logic                m_axi_wvalid,
   input  logic                m_axi_wready,
   output logic [DATA_W-1:0]   m_axi_wdata,
   output logic [DATA_W/8-1:0] m_axi_wstrb,
   input  logic                m_axi_bvalid,
   output logic                m_axi_bready,
   input  logic [1:0]          m_axi_bresp,
   output logic                m_axi_arvalid,
   input  logic                m_axi_arready,
   output logic [ADDR_W-1:0]   m_axi_araddr,
   input  logic                m_axi_rvalid,
   output logic                m_axi_rready,
   input  logic [DATA_W-1:0]   m_axi_rdata,
   input  logic [1:0]          m_axi_rresp,
   input  logic                stat_clr,
   output logic [CNT_W-1:0]    stat_wr_cnt,
   output logic [CNT_W-1:0]    stat_rd_cnt
);

   localparam int WW = DATA_W + DATA_W / 8;
   localparam int RW = DATA_W + 2;

   cl_axil_skid_buf #(.W(ADDR_W)) u_aw (
      .clk_main_a0 (clk_main_a0),
      .rst_main_n  (rst_main_n),
      .in_valid    (s_axi_awvalid),
      .in_ready    (s_axi_awready),
      .in_data     (s_axi_awaddr),
      .out_valid   (m_axi_awvalid),
      .out_ready   (m_axi_awready),
      .out_data    (m_axi_awaddr)
   );

   cl_axil_skid_buf #(.W(WW)) u_w (
      .clk_main_a0 (clk_main_a0),
      .rst_main_n  (rst_main_n),
      .in_valid    (s_axi_wvalid),
      .in_ready    (s_axi_wready),
      .in_data     ({s_axi_wdata, s_axi_wstrb}),
      .out_valid   (m_axi_wvalid),
      .out_ready   (m_axi_wready),
      .out_data    ({m_axi_wdata, m_axi_wstrb})
   );

   cl_axil_skid_buf #(.W(2)) u_b (
      .clk_main_a0 (clk_main_a0),
      .rst_main_n  (rst_main_n),
      .in_valid    (m_axi_bvalid),
      .in_ready    (m_axi_bready),
      .in_data     (m_axi_bresp),
      .out_valid   (s_axi_bvalid),
      .out_ready   (s_axi_bready),
      .out_data    (s_axi_bresp)
   );

   cl_axil_skid_buf #(.W(ADDR_W)) u_ar (
      .clk_main_a0 (clk_main_a0),
      .rst_main_n  (rst_main_n),
      .in_valid    (s_axi_arvalid),
      .in_ready    (s_axi_arready),
      .in_data     (s_axi_araddr),
      .out_valid   (m_axi_arvalid),
      .out_ready   (m_axi_arready),
      .out_data    (m_axi_araddr)
   );

   cl_axil_skid_buf #(.W(RW)) u_r (
      .clk_main_a0 (clk_main_a0),
      .rst_main_n  (rst_main_n),
      .in_valid    (m_axi_rvalid),
      .in_ready    (m_axi_rready),
      .in_data     ({m_axi_rdata, m_axi_rresp}),
      .out_valid   (s_axi_rvalid),
      .out_ready   (s_axi_rready),
      .out_data    ({s_axi_rdata, s_axi_rresp})
   );

`ifdef CL_OCL_SLICE_STATS_EN
   logic [CNT_W-1:0] wr_cnt_q;
   logic [CNT_W-1:0] rd_cnt_q;

   // Clear wins over a same-cycle handshake.
   always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
      if (!rst_main_n) begin
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
      end else if (stat_clr) begin
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
      end else begin
         if (s_axi_bvalid && s_axi_bready)
            wr_cnt_q <= wr_cnt_q + CNT_W'(1);
         if (s_axi_rvalid && s_axi_rready)
            rd_cnt_q <= rd_cnt_q + CNT_W'(1);
      end
   end

   assign stat_wr_cnt = wr_cnt_q;
   assign stat_rd_cnt = rd_cnt_q;
`else
   logic unused_stat_clr;

   assign unused_stat_clr = stat_clr;
   assign stat_wr_cnt     = '0;
   assign stat_rd_cnt     = '0;
`endif

endmodule

// File: tb/tb_cl_ocl_axil_skid_slice.sv
// Directed self-checking bench for cl_ocl_axil_skid_slice.
// Counter expectations follow CL_OCL_SLICE_STATS_EN.
module tb_cl_ocl_axil_skid_slice;
   import cl_ocl_slice_pkg::*;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 4;

   logic                clk_main_a0 = 1'b0;
   logic                rst_main_n;
   logic                s_axi_awvalid, s_axi_awready;
   logic [ADDR_W-1:0]   s_axi_awaddr;
   logic                s_axi_wvalid, s_axi_wready;
   logic [DATA_W-1:0]   s_axi_wdata;
   logic [DATA_W/8-1:0] s_axi_wstrb;
   logic                s_axi_bvalid, s_axi_bready;
   logic [1:0]          s_axi_bresp;
   logic                s_axi_arvalid, s_axi_arready;
   logic [ADDR_W-1:0]   s_axi_araddr;
   logic                s_axi_rvalid, s_axi_rready;
   logic [DATA_W-1:0]   s_axi_rdata;
   logic [1:0]          s_axi_rresp;
   logic                m_axi_awvalid, m_axi_awready;
   logic [ADDR_W-1:0]   m_axi_awaddr;
   logic                m_axi_wvalid, m_axi_wready;
   logic [DATA_W-1:0]   m_axi_wdata;
   logic [DATA_W/8-1:0] m_axi_wstrb;
   logic                m_axi_bvalid, m_axi_bready;
   logic [1:0]          m_axi_bresp;
   logic                m_axi_arvalid, m_axi_arready;
   logic [ADDR_W-1:0]   m_axi_araddr;
   logic                m_axi_rvalid, m_axi_rready;
   logic [DATA_W-1:0]   m_axi_rdata;
   logic [1:0]          m_axi_rresp;
   logic                stat_clr;
   logic [CNT_W-1:0]    stat_wr_cnt, stat_rd_cnt;

   int checks = 0;
   int errors = 0;

`ifdef CL_OCL_SLICE_STATS_EN
   localparam logic [CNT_W-1:0] EXP_ONE = 4'd1;
`else
   localparam logic [CNT_W-1:0] EXP_ONE = 4'd0;
`endif

   always #5 clk_main_a0 = ~clk_main_a0;

   cl_ocl_axil_skid_slice #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk_main_a0   (clk_main_a0),
      .rst_main_n    (rst_main_n),
      .s_axi_awvalid (s_axi_awvalid),
      .s_axi_awready (s_axi_awready),
      .s_axi_awaddr  (s_axi_awaddr),
      .s_axi_wvalid  (s_axi_wvalid),
      .s_axi_wready  (s_axi_wready),
      .s_axi_wdata   (s_axi_wdata),
      .s_axi_wstrb   (s_axi_wstrb),
      .s_axi_bvalid  (s_axi_bvalid),
      .s_axi_bready  (s_axi_bready),
      .s_axi_bresp   (s_axi_bresp),
      .s_axi_arvalid (s_axi_arvalid),
      .s_axi_arready (s_axi_arready),
      .s_axi_araddr  (s_axi_araddr),
      .s_axi_rvalid  (s_axi_rvalid),
      .s_axi_rready  (s_axi_rready),
      .s_axi_rdata   (s_axi_rdata),
      .s_axi_rresp   (s_axi_rresp),
      .m_axi_awvalid (m_axi_awvalid),
      .m_axi_awready (m_axi_awready),
      .m_axi_awaddr  (m_axi_awaddr),
      .m_axi_wvalid  (m_axi_wvalid),
      .m_axi_wready  (m_axi_wready),
      .m_axi_wdata   (m_axi_wdata),
      .m_axi_wstrb   (m_axi_wstrb),
      .m_axi_bvalid  (m_axi_bvalid),
      .m_axi_bready  (m_axi_bready),
      .m_axi_bresp   (m_axi_bresp),
      .m_axi_arvalid (m_axi_arvalid),
      .m_axi_arready (m_axi_arready),
      .m_axi_araddr  (m_axi_araddr),
      .m_axi_rvalid  (m_axi_rvalid),
      .m_axi_rready  (m_axi_rready),
      .m_axi_rdata   (m_axi_rdata),
      .m_axi_rresp   (m_axi_rresp),
      .stat_clr      (stat_clr),
      .stat_wr_cnt   (stat_wr_cnt),
      .stat_rd_cnt   (stat_rd_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_main_a0);
      #1;
   endtask

   function automatic logic [4:0] out_valids();
      return {m_axi_awvalid, m_axi_wvalid, s_axi_bvalid,
              m_axi_arvalid, s_axi_rvalid};
   endfunction

   function automatic logic [4:0] in_readys();
      return {s_axi_awready, s_axi_wready, m_axi_bready,
              s_axi_arready, m_axi_rready};
   endfunction

   initial begin
      rst_main_n    = 1'b0;
      s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h100;
      s_axi_wvalid  = 1'b1; s_axi_wdata  = 32'h200;
      s_axi_wstrb   = 4'hF;
      s_axi_arvalid = 1'b1; s_axi_araddr = 32'h300;
      m_axi_bvalid  = 1'b1; m_axi_bresp  = 2'b11;
      m_axi_rvalid  = 1'b1; m_axi_rdata  = 32'h400;
      m_axi_rresp   = 2'b11;
      s_axi_bready  = 1'b1; s_axi_rready = 1'b1;
      m_axi_awready = 1'b1; m_axi_wready = 1'b1;
      m_axi_arready = 1'b1;
      stat_clr      = 1'b0;

      step(); step();
      chk("rst_valids", 64'(out_valids()), 64'h0);
      chk("rst_readys", 64'(in_readys()), 64'h0);
      chk("rst_awaddr", 64'(m_axi_awaddr), 64'h0);
      chk("rst_wr_cnt", 64'(stat_wr_cnt), 64'h0);

      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      s_axi_arvalid = 1'b0; m_axi_bvalid = 1'b0;
      m_axi_rvalid  = 1'b0;
      rst_main_n    = 1'b1;
      #1;
      chk("rel_readys_lo", 64'(in_readys()), 64'h0);
      step();
      chk("rel_readys_hi", 64'(in_readys()), 64'h1F);
      chk("rel_valids", 64'(out_valids()), 64'h0);

      for (int k = 0; k <= 16; k++) begin
         if (k > 0) begin
            chk("ar_valid", 64'(m_axi_arvalid), 64'h1);
            chk("ar_addr", 64'(m_axi_araddr), 64'(4 * (k - 1)));
         end
         chk("ar_ready", 64'(s_axi_arready), 64'h1);
         s_axi_arvalid = (k < 16);
         s_axi_araddr  = 32'(4 * k);
         step();
      end
      chk("ar_drain", 64'(m_axi_arvalid), 64'h0);

      s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h1234_5678;
      step();
      s_axi_awvalid = 1'b0;
      chk("aw_addr", 64'(m_axi_awaddr), 64'h1234_5678);
      chk("aw_valid", 64'(m_axi_awvalid), 64'h1);
      step();
      chk("aw_drain", 64'(m_axi_awvalid), 64'h0);

      m_axi_wready = 1'b0;
      s_axi_wvalid = 1'b1; s_axi_wdata = 32'hA; s_axi_wstrb = 4'h1;
      step();
      chk("bp_rdy1", 64'(s_axi_wready), 64'h1);
      s_axi_wdata = 32'hB; s_axi_wstrb = 4'h2;
      step();
      chk("bp_rdy2", 64'(s_axi_wready), 64'h0);
      s_axi_wdata = 32'hC; s_axi_wstrb = 4'h4;
      step();
      chk("bp_rdy3", 64'(s_axi_wready), 64'h0);
      chk("bp_a", 64'({m_axi_wvalid, m_axi_wdata, m_axi_wstrb}),
          64'h1_0000_000A_1);
      m_axi_wready = 1'b1;
      step();
      chk("bp_b", 64'({m_axi_wvalid, m_axi_wdata, m_axi_wstrb}),
          64'h1_0000_000B_2);
      chk("bp_rdy4", 64'(s_axi_wready), 64'h1);
      step();
      s_axi_wvalid = 1'b0;
      chk("bp_c", 64'({m_axi_wvalid, m_axi_wdata, m_axi_wstrb}),
          64'h1_0000_000C_4);
      step();
      chk("bp_drain", 64'(m_axi_wvalid), 64'h0);

      m_axi_rvalid = 1'b1; m_axi_rdata = 32'hDEAD_BEEF;
      m_axi_rresp  = AXIL_RESP_SLVERR;
      step();
      m_axi_rvalid = 1'b0;
      chk("r_valid", 64'(s_axi_rvalid), 64'h1);
      chk("r_data", 64'(s_axi_rdata), 64'hDEAD_BEEF);
      chk("r_resp", 64'(s_axi_rresp), 64'h2);
      step();
      chk("r_drain", 64'(s_axi_rvalid), 64'h0);
      chk("rd_cnt1", 64'(stat_rd_cnt), 64'(EXP_ONE));

      for (int k = 0; k <= 17; k++) begin
         if (k > 0) begin
            chk("b_valid", 64'(s_axi_bvalid), 64'h1);
            chk("b_resp", 64'(s_axi_bresp), 64'((k - 1) % 4));
         end
         m_axi_bvalid = (k < 17);
         m_axi_bresp  = 2'(k);
         step();
      end
      chk("b_drain", 64'(s_axi_bvalid), 64'h0);
      chk("b_ready", 64'(m_axi_bready), 64'h1);
      chk("wr_cnt_wrap", 64'(stat_wr_cnt), 64'(EXP_ONE));

      m_axi_rvalid = 1'b1; m_axi_rdata = 32'h1111_2222;
      m_axi_rresp  = AXIL_RESP_OKAY;
      step();
      m_axi_rvalid = 1'b0;
      stat_clr     = 1'b1;
      chk("clr_rvalid", 64'(s_axi_rvalid), 64'h1);
      chk("clr_rdata", 64'(s_axi_rdata), 64'h1111_2222);
      step();
      stat_clr = 1'b0;
      chk("clr_rd_cnt", 64'(stat_rd_cnt), 64'h0);
      chk("clr_wr_cnt", 64'(stat_wr_cnt), 64'h0);

      m_axi_wready = 1'b0;
      s_axi_wvalid = 1'b1; s_axi_wdata = 32'h55; s_axi_wstrb = 4'hF;
      step();
      s_axi_wdata = 32'h66;
      step();
      s_axi_wvalid = 1'b0;
      chk("mr_two", 64'(s_axi_wready), 64'h0);
      chk("mr_wv", 64'(m_axi_wvalid), 64'h1);
      rst_main_n = 1'b0;
      #1;
      chk("mr_valids", 64'(out_valids()), 64'h0);
      chk("mr_readys", 64'(in_readys()), 64'h0);
      step();
      rst_main_n = 1'b1;
      step();
      step();
      chk("mr_wv_post", 64'(m_axi_wvalid), 64'h0);
      chk("mr_wdata", 64'(m_axi_wdata), 64'h0);
      chk("mr_wready", 64'(s_axi_wready), 64'h1);
      m_axi_wready = 1'b1;
      step();
      chk("mr_no_stale", 64'(m_axi_wvalid), 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
